// File: rtl/can_bit_destuff_pkg.sv
// Shared CAN receive-path constants: FSM state codes, default stuff length, bus levels.
// Latency: n/a (constants only).
// Backpressure: n/a (constants only).
package can_bit_destuff_pkg;

  // Destuffer FSM state codes
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RUN  = 2'd1;
  localparam state_t S_ERR  = 2'd2;

  // CAN inserts a complement bit after five identical bits
  localparam int CAN_STUFF_LEN = 5;

  // Bus levels as seen by the bit sampler
  localparam logic DOMINANT  = 1'b0;
  localparam logic RECESSIVE = 1'b1;

endpackage

// File: rtl/can_run_counter.sv
// Tracks the value of the current run of identical bits and its length.
// Latency: cnt/last update one clk after a load/inc/clr request; run_hit decodes the registered count.
// Backpressure: none; the controller issues at most one request per cycle (clr > load > inc).
module can_run_counter
  import can_bit_destuff_pkg::*;
#(
  parameter int STUFF_LEN = CAN_STUFF_LEN,
  parameter int CNT_W     = $clog2(STUFF_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             inc,
  input  logic             bit_in,
  output logic [CNT_W-1:0] cnt,
  output logic             last,
  output logic             run_hit
);

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(STUFF_LEN);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;

  // Next run state: clear wins, load starts a new run, inc extends the current one
  always_comb begin
    cnt_d  = cnt_q;
    last_d = last_q;
    if (clr) begin
      cnt_d  = CNT_ZERO;
      last_d = DOMINANT;
    end else if (load) begin
      cnt_d  = CNT_ONE;
      last_d = bit_in;
    end else if (inc) begin
      cnt_d  = cnt_q + CNT_ONE;
      last_d = bit_in;
    end
  end

  // Run registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= CNT_ZERO;
      last_q <= DOMINANT;
    end else begin
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

  assign cnt     = cnt_q;
  assign last    = last_q;
  assign run_hit = (cnt_q == CNT_FULL);

endmodule

// File: rtl/can_bit_destuff.sv
// CAN receive bit destuffer: drops the stuff bit after STUFF_LEN identical bits and flags stuff errors.
// Latency: dout/dout_valid/stuff_err registered, one clk after the qualifying din_valid edge.
// Backpressure: none; din_valid is a strobe and downstream must take every dout_valid pulse.
module can_bit_destuff
  import can_bit_destuff_pkg::*;
#(
  parameter int STUFF_LEN = CAN_STUFF_LEN,
  parameter int CNT_W     = $clog2(STUFF_LEN + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic din_valid,
  input  logic din,
  output logic dout,
  output logic dout_valid,
  output logic stuff_err,
  output logic busy
);

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  state_t           state_q, state_d;
  logic             dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             stuff_err_q, stuff_err_d;

  logic             cnt_clr, cnt_load, cnt_inc;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic             skip;
  logic             stuff_bad;

  // The bit after a full-length run is the stuff bit; it is pending exactly while the run is full
  can_run_counter #(
    .STUFF_LEN (STUFF_LEN),
    .CNT_W     (CNT_W)
  ) u_run (
    .clk     (clk),
    .rst     (rst),
    .clr     (cnt_clr),
    .load    (cnt_load),
    .inc     (cnt_inc),
    .bit_in  (din),
    .cnt     (cnt),
    .last    (last),
    .run_hit (skip)
  );

  // A stuff bit must be the complement of the run it terminates
  assign stuff_bad = din_valid && skip && (din == last);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: en opens/closes the window, a bad stuff bit parks in ERR until en drops
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (en) state_d = S_RUN;
      end
      S_RUN: begin
        if (!en)            state_d = S_IDLE;
        else if (stuff_bad) state_d = S_ERR;
      end
      S_ERR: begin
        if (!en) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and run-counter control per state
  always_comb begin
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    stuff_err_d  = 1'b0;
    cnt_clr      = 1'b0;
    cnt_load     = 1'b0;
    cnt_inc      = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Outside the stuffed region every sampled bit is passed straight through
        cnt_clr = 1'b1;
        if (din_valid) begin
          dout_d       = din;
          dout_valid_d = 1'b1;
        end
      end
      S_RUN: begin
        if (!en) begin
          // Window closed: the bit arriving now already belongs to the unstuffed region
          cnt_clr = 1'b1;
          if (din_valid) begin
            dout_d       = din;
            dout_valid_d = 1'b1;
          end
        end else if (din_valid) begin
          if (skip) begin
            if (din != last) begin
              // Valid stuff bit: swallow it, it starts the next run
              cnt_load = 1'b1;
            end else begin
              stuff_err_d = 1'b1;
            end
          end else begin
            dout_d       = din;
            dout_valid_d = 1'b1;
            // cnt==0 marks the first bit of the window, whose run always starts fresh
            if ((cnt == CNT_ZERO) || (din != last)) begin
              cnt_load = 1'b1;
            end else begin
              cnt_inc = 1'b1;
            end
          end
        end
      end
      S_ERR: begin
        // Frame is already lost; keep the counter idle so IDLE is entered clean
        cnt_clr = 1'b1;
      end
      default: begin
        cnt_clr = 1'b1;
      end
    endcase
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q       <= DOMINANT;
      dout_valid_q <= 1'b0;
      stuff_err_q  <= 1'b0;
    end else begin
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      stuff_err_q  <= stuff_err_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign stuff_err  = stuff_err_q;
  assign busy       = (state_q == S_RUN);

endmodule
